// File: rtl/ov5640_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ov5640_pkg
//  Description : Shared types and constants for the OV5640 SCCB register
//                bring-up sequencer: state encoding, table entry layout and
//                the reserved address that marks a delay entry.
//  Revision    : 1.0 - initial release
// ============================================================================
package ov5640_pkg;

    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 8;
    localparam int ENTRY_W = ADDR_W + DATA_W;

    // A table entry with this address is not written to the sensor; its data
    // byte is a delay in milliseconds.
    localparam logic [ADDR_W-1:0] DLY_ADDR = 16'hFFFF;

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        PWRUP = 4'd1,
        FETCH = 4'd2,
        ISSUE = 4'd3,
        DELAY = 4'd4,
        WAIT  = 4'd5,
        GAP   = 4'd6,
        DONE  = 4'd7,
        ERROR = 4'd8
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

endpackage : ov5640_pkg
`default_nettype wire

// File: rtl/ov5640_reg_rom.sv
`default_nettype none
// ============================================================================
//  Module      : ov5640_reg_rom
//  Description : OV5640 VGA/RGB565 register table. Synchronous ROM with one
//                cycle of read latency.
//  Ports       : clk      in   1   clock
//                i_index  in   8   table index
//                o_entry  out  24  {reg_addr[15:0], data[7:0]} of i_index,
//                                  valid one cycle after the index
//  Revision    : 1.0 - initial release
// ============================================================================
module ov5640_reg_rom
    import ov5640_pkg::*;
(
    input  logic               clk,
    input  logic [7:0]         i_index,
    output logic [ENTRY_W-1:0] o_entry
);

    logic [ENTRY_W-1:0] w_entry;
    logic [ENTRY_W-1:0] r_entry;

    always_comb begin
        w_entry = '0;
        case (i_index)
            8'd0:  w_entry = 24'h3008_82;   // software reset
            8'd1:  w_entry = 24'hFFFF_02;   // let the reset settle
            8'd2:  w_entry = 24'h3008_42;   // power down while configuring
            8'd3:  w_entry = 24'h3103_03;
            8'd4:  w_entry = 24'h3017_FF;
            8'd5:  w_entry = 24'h3018_FF;
            8'd6:  w_entry = 24'h3034_1A;
            8'd7:  w_entry = 24'h3035_11;
            8'd8:  w_entry = 24'h3036_46;
            8'd9:  w_entry = 24'h3037_13;
            8'd10: w_entry = 24'h3108_01;
            8'd11: w_entry = 24'h3630_36;
            8'd12: w_entry = 24'h3631_0E;
            8'd13: w_entry = 24'h3632_E2;
            8'd14: w_entry = 24'h3633_12;
            8'd15: w_entry = 24'h3621_E0;
            8'd16: w_entry = 24'h3704_A0;
            8'd17: w_entry = 24'h3703_5A;
            8'd18: w_entry = 24'h3715_78;
            8'd19: w_entry = 24'h3717_01;
            8'd20: w_entry = 24'h370B_60;
            8'd21: w_entry = 24'h3705_1A;
            8'd22: w_entry = 24'h3905_02;
            8'd23: w_entry = 24'h3906_10;
            8'd24: w_entry = 24'h3901_0A;
            8'd25: w_entry = 24'h3731_12;
            8'd26: w_entry = 24'h3600_08;
            8'd27: w_entry = 24'h3601_33;
            8'd28: w_entry = 24'h302D_60;
            8'd29: w_entry = 24'h3620_52;
            8'd30: w_entry = 24'h371B_20;
            8'd31: w_entry = 24'h471C_50;
            8'd32: w_entry = 24'h3A13_43;
            8'd33: w_entry = 24'h3A18_00;
            8'd34: w_entry = 24'h3A19_F8;
            8'd35: w_entry = 24'h3635_13;
            8'd36: w_entry = 24'h3636_03;
            8'd37: w_entry = 24'h3634_40;
            8'd38: w_entry = 24'h3622_01;
            8'd39: w_entry = 24'h3C01_34;
            8'd40: w_entry = 24'h3C04_28;
            8'd41: w_entry = 24'h3C05_98;
            8'd42: w_entry = 24'h3C06_00;
            8'd43: w_entry = 24'h3C07_08;
            8'd44: w_entry = 24'h3C08_00;
            8'd45: w_entry = 24'h3C09_1C;
            8'd46: w_entry = 24'h3C0A_9C;
            8'd47: w_entry = 24'h3C0B_40;
            8'd48: w_entry = 24'h3820_41;
            8'd49: w_entry = 24'h3821_07;
            8'd50: w_entry = 24'h3814_31;
            8'd51: w_entry = 24'h3815_31;
            8'd52: w_entry = 24'h3800_00;
            8'd53: w_entry = 24'h3801_00;
            8'd54: w_entry = 24'h3802_00;
            8'd55: w_entry = 24'h3803_04;
            8'd56: w_entry = 24'h3808_02;   // output width  640
            8'd57: w_entry = 24'h3809_80;
            8'd58: w_entry = 24'h380A_01;   // output height 480
            8'd59: w_entry = 24'h380B_E0;
            8'd60: w_entry = 24'h4300_61;   // RGB565
            8'd61: w_entry = 24'h501F_01;
            8'd62: w_entry = 24'h4740_21;
            8'd63: w_entry = 24'h3008_02;   // wake up
            default: w_entry = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        r_entry <= w_entry;
    end

    assign o_entry = r_entry;

endmodule : ov5640_reg_rom
`default_nettype wire

// File: rtl/ov5640_init_seq.sv
`default_nettype none
// ============================================================================
//  Module      : ov5640_init_seq
//  Description : OV5640 SCCB register bring-up sequencer. Walks the register
//                table, hands each write to a single-transaction I2C engine
//                via start/done, inserts table-driven millisecond delays and
//                reports completion or abort (NACK / engine timeout).
//  Ports       : meg25      in   1   system clock
//                reset      in   1   synchronous active-high reset
//                start      in   1   begin/restart pulse (IDLE/DONE/ERROR)
//                i2c_start  out  1   transaction start pulse
//                i2c_data   out  24  {reg_addr, data}, stable until i2c_done
//                i2c_done   in   1   transaction finished pulse
//                i2c_nack   in   1   NACK flag, valid with i2c_done
//                init_done  out  1   all entries written
//                init_err   out  1   sequence aborted
//                step       out  8   current table index
//  Build macro : OV5640_INIT_RETRY_EN - retry a NACKed entry up to MAX_RETRY
//                times before aborting. Undefined: first NACK aborts.
//  Revision    : 1.0 - initial release
// ============================================================================
module ov5640_init_seq
    import ov5640_pkg::*;
#(
    parameter int NUM_REGS    = 64,
    parameter int CLK_HZ      = 25_000_000,
    parameter int PWRUP_MS    = 20,
    parameter int GAP_CYC     = 250,
    parameter int TIMEOUT_CYC = 200_000
`ifdef OV5640_INIT_RETRY_EN
    ,
    parameter int MAX_RETRY   = 3
`endif
)(
    input  logic               meg25,
    input  logic               reset,
    input  logic               start,
    output logic               i2c_start,
    output logic [ENTRY_W-1:0] i2c_data,
    input  logic               i2c_done,
    input  logic               i2c_nack,
    output logic               init_done,
    output logic               init_err,
    output logic [7:0]         step
);

    localparam int TO_W  = $clog2(TIMEOUT_CYC);
    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    localparam logic [14:0]      c_TICK_LAST = 15'(CLK_HZ / 1000 - 1);
    localparam logic [7:0]       c_PWRUP_MS  = 8'(PWRUP_MS);
    localparam logic [TO_W-1:0]  c_TO_LAST   = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [GAP_W-1:0] c_GAP_LAST  = GAP_W'(GAP_CYC - 1);
    localparam logic [7:0]       c_LAST_STEP = 8'(NUM_REGS - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    entry_t             r_entry;
    entry_t             w_rom_entry;
    logic [ENTRY_W-1:0] w_rom_q;
    logic [7:0]         r_step;
    logic [14:0]        r_ms_cnt;
    logic [7:0]         r_dly_cnt;
    logic [GAP_W-1:0]   r_gap_cnt;
    logic [TO_W-1:0]    r_to_cnt;

    logic w_start_ok;       // start accepted this cycle
    logic w_ms_tick;        // last cycle of the current millisecond
    logic w_last;           // current entry is the final table entry
    logic w_adv;            // current entry completed successfully
    logic w_nack_ev;        // engine reported a NACK for the current entry
    logic w_retry_ok;       // a NACK may be retried rather than aborting
    logic w_gap_to_issue;   // this gap precedes a retry of the same entry

    // ------------------------------------------------------------------
    // Register table. The index only changes on entry completion, which is
    // always followed by at least one GAP cycle, so the ROM output already
    // reflects r_step when FETCH is reached.
    // ------------------------------------------------------------------
    ov5640_reg_rom u_rom (
        .clk     (meg25),
        .i_index (r_step),
        .o_entry (w_rom_q)
    );

    assign w_rom_entry = entry_t'(w_rom_q);
    assign w_start_ok  = start && ((r_state == IDLE) || (r_state == DONE) ||
                                   (r_state == ERROR));
    assign w_ms_tick   = (r_ms_cnt == c_TICK_LAST);
    assign w_last      = (r_step == c_LAST_STEP);
    assign w_nack_ev   = (r_state == WAIT) && i2c_done && i2c_nack;

`ifdef OV5640_INIT_RETRY_EN
    localparam int RT_W = $clog2(MAX_RETRY + 1);
    localparam logic [RT_W-1:0] c_RETRY_MAX = RT_W'(MAX_RETRY);

    logic [RT_W-1:0] r_retry_cnt;
    logic            r_retry_pend;

    assign w_retry_ok     = (r_retry_cnt != c_RETRY_MAX);
    assign w_gap_to_issue = r_retry_pend;

    always_ff @(posedge meg25) begin
        if (reset) begin
            r_retry_cnt  <= '0;
            r_retry_pend <= 1'b0;
        end else if (w_start_ok || w_adv) begin
            r_retry_cnt  <= '0;
            r_retry_pend <= 1'b0;
        end else if (w_nack_ev && w_retry_ok) begin
            r_retry_cnt  <= r_retry_cnt + 1'b1;
            r_retry_pend <= 1'b1;
        end else if (r_state == ISSUE) begin
            r_retry_pend <= 1'b0;
        end
    end
`else
    assign w_retry_ok     = 1'b0;
    assign w_gap_to_issue = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge meg25) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_adv       = 1'b0;
        case (r_state)
            IDLE, DONE, ERROR: begin
                if (w_start_ok) w_state_nxt = PWRUP;
            end
            PWRUP: begin
                if (r_dly_cnt == c_PWRUP_MS) w_state_nxt = FETCH;
            end
            FETCH: begin
                if (w_rom_entry.addr == DLY_ADDR) begin
                    if (w_rom_entry.data == '0) begin
                        // zero-length delay completes on the spot
                        w_adv       = 1'b1;
                        w_state_nxt = w_last ? DONE : GAP;
                    end else begin
                        w_state_nxt = DELAY;
                    end
                end else begin
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                w_state_nxt = WAIT;
            end
            WAIT: begin
                if (i2c_done) begin
                    if (!i2c_nack) begin
                        w_adv       = 1'b1;
                        w_state_nxt = w_last ? DONE : GAP;
                    end else if (w_retry_ok) begin
                        w_state_nxt = GAP;
                    end else begin
                        w_state_nxt = ERROR;
                    end
                end else if (r_to_cnt == c_TO_LAST) begin
                    w_state_nxt = ERROR;
                end
            end
            DELAY: begin
                if (r_dly_cnt == r_entry.data) begin
                    w_adv       = 1'b1;
                    w_state_nxt = w_last ? DONE : GAP;
                end
            end
            GAP: begin
                if (r_gap_cnt == c_GAP_LAST) begin
                    w_state_nxt = w_gap_to_issue ? ISSUE : FETCH;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    always_comb begin
        i2c_start = 1'b0;
        init_done = 1'b0;
        init_err  = 1'b0;
        case (r_state)
            ISSUE:   i2c_start = 1'b1;
            DONE:    init_done = 1'b1;
            ERROR:   init_err  = 1'b1;
            default: ;
        endcase
    end

    assign i2c_data = r_entry;
    assign step     = r_step;

    // ------------------------------------------------------------------
    // Table index and latched entry. The entry register doubles as the
    // i2c_data holding register for the whole transaction.
    // ------------------------------------------------------------------
    always_ff @(posedge meg25) begin
        if (reset) begin
            r_step  <= '0;
            r_entry <= '0;
        end else begin
            if (r_state == FETCH) r_entry <= w_rom_entry;
            if (w_start_ok) begin
                r_step <= '0;
            end else if (w_adv && !w_last) begin
                r_step <= r_step + 8'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Millisecond prescaler and ms counter, shared by power-up wait and
    // table delays (the two never overlap; FETCH between them clears).
    // ------------------------------------------------------------------
    always_ff @(posedge meg25) begin
        if (reset) begin
            r_ms_cnt  <= '0;
            r_dly_cnt <= '0;
        end else if ((r_state == PWRUP) || (r_state == DELAY)) begin
            if (w_ms_tick) begin
                r_ms_cnt  <= '0;
                r_dly_cnt <= r_dly_cnt + 8'd1;
            end else begin
                r_ms_cnt  <= r_ms_cnt + 15'd1;
            end
        end else begin
            r_ms_cnt  <= '0;
            r_dly_cnt <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Gap and transaction-timeout counters. The timeout counter is zero in
    // the ISSUE cycle and equals the number of cycles since i2c_start while
    // in WAIT, so an unanswered transaction aborts TIMEOUT_CYC cycles after
    // its start pulse.
    // ------------------------------------------------------------------
    always_ff @(posedge meg25) begin
        if (reset) begin
            r_gap_cnt <= '0;
            r_to_cnt  <= '0;
        end else begin
            r_gap_cnt <= (r_state == GAP) ? r_gap_cnt + 1'b1 : '0;
            r_to_cnt  <= ((r_state == ISSUE) || (r_state == WAIT)) ?
                         r_to_cnt + 1'b1 : '0;
        end
    end

endmodule : ov5640_init_seq
`default_nettype wire

// File: tb/tb_ov5640_init_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ov5640_init_seq
//  Description : Self-checking bench for ov5640_init_seq. A behavioural I2C
//                engine answers each transaction; expected i2c_data values
//                are queued ahead of each run and popped on every i2c_start.
//                Expectations for the NACK case follow OV5640_INIT_RETRY_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ov5640_init_seq;

    localparam int NUM_REGS    = 5;
    localparam int CLK_HZ      = 100_000;
    localparam int PWRUP_MS    = 2;
    localparam int GAP_CYC     = 10;
    localparam int TIMEOUT_CYC = 500;
    localparam int TICK        = CLK_HZ / 1000;
    localparam int ENG_LAT     = 100;
`ifdef OV5640_INIT_RETRY_EN
    localparam int NACK_TRIES  = 4;
`else
    localparam int NACK_TRIES  = 1;
`endif

    // table entries the sequencer writes with NUM_REGS=5 (index 1 is a delay)
    localparam logic [23:0] E0 = 24'h3008_82;
    localparam logic [23:0] E2 = 24'h3008_42;
    localparam logic [23:0] E3 = 24'h3103_03;
    localparam logic [23:0] E4 = 24'h3017_FF;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        i2c_start;
    logic [23:0] i2c_data;
    logic        i2c_done;
    logic        i2c_nack;
    logic        init_done;
    logic        init_err;
    logic [7:0]  step;

    int          n_tests  = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          n_starts = 0;
    int          start_cyc[$];
    logic [23:0] exp_q[$];

    bit          eng_respond = 1'b1;
    bit          eng_nack_en = 1'b0;
    logic [23:0] nack_data   = '0;

    ov5640_init_seq #(
        .NUM_REGS    (NUM_REGS),
        .CLK_HZ      (CLK_HZ),
        .PWRUP_MS    (PWRUP_MS),
        .GAP_CYC     (GAP_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .meg25     (clk),
        .reset     (reset),
        .start     (start),
        .i2c_start (i2c_start),
        .i2c_data  (i2c_data),
        .i2c_done  (i2c_done),
        .i2c_nack  (i2c_nack),
        .init_done (init_done),
        .init_err  (init_err),
        .step      (step)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    // Scoreboard: every start pulse must carry the next queued entry.
    always @(negedge clk) begin
        logic [23:0] e;
        bit          have;
        if (i2c_start === 1'b1) begin
            n_starts++;
            start_cyc.push_back(cyc);
            have = (exp_q.size() != 0);
            e    = 24'hxxxxxx;
            if (have) e = exp_q.pop_front();
            check("i2c_data", {7'd0, have, i2c_data}, {7'd0, 1'b1, e});
        end
    end

    // I2C engine model: answers ENG_LAT cycles after i2c_start; shares reset.
    initial begin
        int          eng_cnt;
        bit          eng_busy;
        logic [23:0] eng_data;
        i2c_done = 1'b0;
        i2c_nack = 1'b0;
        eng_cnt  = 0;
        eng_busy = 1'b0;
        eng_data = '0;
        forever begin
            @(negedge clk);
            i2c_done = 1'b0;
            i2c_nack = 1'b0;
            if (reset === 1'b1) begin
                eng_busy = 1'b0;
            end else if (eng_busy) begin
                eng_cnt--;
                if (eng_cnt == 0) begin
                    i2c_done = 1'b1;
                    i2c_nack = eng_nack_en && (eng_data == nack_data);
                    eng_busy = 1'b0;
                end
            end
            if ((i2c_start === 1'b1) && eng_respond && (reset !== 1'b1)) begin
                eng_busy = 1'b1;
                eng_cnt  = ENG_LAT;
                eng_data = i2c_data;
            end
        end
    end

    initial begin
        int k;
        int base;
        int err_cyc;
        reset = 1'b1;
        start = 1'b0;

        // ---- reset state ----
        tick(3);
        check("rst_i2c_start", i2c_start, 0);
        check("rst_i2c_data",  i2c_data,  0);
        check("rst_init_done", init_done, 0);
        check("rst_init_err",  init_err,  0);
        check("rst_step",      step,      0);
        reset = 1'b0;
        tick(5);
        check("idle_no_start", n_starts, 0);

        // ---- reset in the middle of a transaction ----
        exp_q.push_back(E0);
        pulse_start();
        k = 0;
        while (n_starts < 1 && k < 1000) begin tick(1); k++; end
        check("t1_first_start", n_starts, 1);
        tick(20);
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(1);
        check("t1_i2c_start", i2c_start, 0);
        check("t1_init_done", init_done, 0);
        check("t1_init_err",  init_err,  0);
        check("t1_step",      step,      0);
        tick(400);
        check("t1_stays_idle", n_starts, 1);

        // ---- full run, delay entry, start ignored while in WAIT ----
        base = n_starts;
        exp_q.push_back(E0);
        exp_q.push_back(E2);
        exp_q.push_back(E3);
        exp_q.push_back(E4);
        pulse_start();
        k = 0;
        while (n_starts < base + 2 && k < 3000) begin tick(1); k++; end
        check("t3_reached_entry2", n_starts - base, 2);
        tick(5);
        pulse_start();
        tick(3);
        check("t6_wait_start_step", step, 2);
        k = 0;
        while (init_done !== 1'b1 && k < 5000) begin tick(1); k++; end
        check("t2_init_done", init_done, 1);
        check("t2_init_err",  init_err,  0);
        check("t2_step_end",  step,      NUM_REGS - 1);
        check("t2_start_cnt", n_starts - base, 4);
        check("t2_queue_empty", exp_q.size(), 0);
        check("t3_delay_len_ok",
              32'(start_cyc[base + 1] - start_cyc[base] >= 2 * TICK), 1);
        tick(300);
        check("t2_done_hold",     init_done, 1);
        check("t2_no_extra_start", n_starts - base, 4);

        // ---- NACK on entry 2 ----
        eng_nack_en = 1'b1;
        nack_data   = E2;
        base        = n_starts;
        exp_q.push_back(E0);
        for (int i = 0; i < NACK_TRIES; i++) exp_q.push_back(E2);
        pulse_start();
        check("t4_done_cleared", init_done, 0);
        k = 0;
        while (init_err !== 1'b1 && k < 5000) begin tick(1); k++; end
        check("t4_init_err",   init_err,  1);
        check("t4_init_done",  init_done, 0);
        check("t4_step",       step,      2);
        check("t4_start_cnt",  n_starts - base, 1 + NACK_TRIES);
        check("t4_queue_empty", exp_q.size(), 0);

        // ---- restart from ERROR, engine never answers ----
        eng_nack_en = 1'b0;
        eng_respond = 1'b0;
        base        = n_starts;
        exp_q.push_back(E0);
        pulse_start();
        check("t6_err_cleared", init_err, 0);
        check("t6_step_zero",   step,     0);
        k = 0;
        while (n_starts < base + 1 && k < 1000) begin tick(1); k++; end
        check("t5_one_start", n_starts - base, 1);
        k = 0;
        while (init_err !== 1'b1 && k < 2000) begin tick(1); k++; end
        err_cyc = cyc;
        check("t5_init_err", init_err, 1);
        check("t5_timeout_cycles", err_cyc - start_cyc[start_cyc.size() - 1],
              TIMEOUT_CYC);
        tick(300);
        check("t5_no_more_start", n_starts - base, 1);
        check("t5_step",          step, 0);
        check("t5_queue_empty",   exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_ov5640_init_seq
`default_nettype wire
